// File: rtl/timestamp_tagger.sv
// Timestamp tagger: stamps events with an 8-bit tick counter, queues them in a FIFO and
// streams byte-wide event/sync frames to a serializer over a valid/ready handshake.
module timestamp_tagger #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_PERIOD = 128
) (
  input  logic              clk_128M,
  input  logic              reset_128M,
  input  logic              tick_in,
  input  logic              event_valid,
  input  logic [DATA_W-1:0] event_data,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sof,
  output logic [7:0]        timestamp_now,
  output logic [15:0]       overflow_count
);

  localparam int NBYTES = DATA_W / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int EW     = 8 + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_TS, S_DATA} state_t;

  state_t              state_q, state_d;
  logic [7:0]          ts_q;
  logic [7:0]          sync_q, sync_d;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [15:0]         ovf_q;
  logic [7:0]          frame_ts_q, frame_ts_d;
  logic [DATA_W-1:0]   frame_data_q, frame_data_d;
  logic                frame_sync_q, frame_sync_d;
  logic [KW-1:0]       k_q, k_d;
  logic                full, empty, push, pop, launch_sync, hs;
  logic [7:0]          data_bytes [NBYTES];

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = event_valid && !full;
  assign hs    = tx_valid && tx_ready;

  assign timestamp_now  = ts_q;
  assign overflow_count = ovf_q;

  // Payload is sent most-significant byte first.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
    assign data_bytes[gi] = frame_data_q[DATA_W-1-8*gi -: 8];
  end

  // Event storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_128M) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {ts_q, event_data};
    end
  end

  always_ff @(posedge clk_128M or posedge reset_128M) begin
    if (reset_128M) begin
      state_q      <= S_IDLE;
      ts_q         <= '0;
      sync_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= '0;
      frame_ts_q   <= '0;
      frame_data_q <= '0;
      frame_sync_q <= 1'b0;
      k_q          <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      frame_ts_q   <= frame_ts_d;
      frame_data_q <= frame_data_d;
      frame_sync_q <= frame_sync_d;
      k_q          <= k_d;
      count_q      <= count_q + CW'(push) - CW'(pop);
      if (tick_in) ts_q <= ts_q + 8'd1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      // Fullness is judged at cycle start, so a same-cycle pop does not save the event.
      if (event_valid && full && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_ts_d   = frame_ts_q;
    frame_data_d = frame_data_q;
    frame_sync_d = frame_sync_q;
    k_d          = k_q;
    pop          = 1'b0;
    launch_sync  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          frame_ts_d   = mem_q[rd_ptr_q][EW-1 -: 8];
          frame_data_d = mem_q[rd_ptr_q][DATA_W-1:0];
          frame_sync_d = 1'b0;
          state_d      = S_HDR;
        end else if (sync_q == 8'(SYNC_PERIOD)) begin
          launch_sync  = 1'b1;
          frame_ts_d   = ts_q;
          frame_sync_d = 1'b1;
          state_d      = S_HDR;
        end
      end
      S_HDR: if (hs) state_d = S_TS;
      S_TS: begin
        if (hs) begin
          k_d     = '0;
          state_d = frame_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          if (k_q == KW'(NBYTES - 1)) state_d = S_IDLE;
          else k_d = k_q + KW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sync counter restarts on any frame launch; a launch wins over a tick in that cycle.
  always_comb begin
    sync_d = sync_q;
    if (pop || launch_sync) sync_d = '0;
    else if (tick_in && sync_q != 8'(SYNC_PERIOD)) sync_d = sync_q + 8'd1;
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_sof   = 1'b0;
    tx_byte  = '0;
    case (state_q)
      S_HDR: begin
        tx_valid = 1'b1;
        tx_sof   = 1'b1;
        tx_byte  = frame_sync_q ? 8'h5A : 8'hA5;
      end
      S_TS: begin
        tx_valid = 1'b1;
        tx_byte  = frame_ts_q;
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_byte  = data_bytes[k_q];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timestamp_tagger.sv
// Randomized bench for timestamp_tagger: a queue-based reference model predicts every
// accepted byte, the timestamp, overflow count and when frames must launch.
module tb_timestamp_tagger;
  localparam int DATA_W = 16, FIFO_DEPTH = 8, SYNC_PERIOD = 128, NB = DATA_W / 8;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, ev = 1'b0, rdy = 1'b1;
  logic [DATA_W-1:0] evd = '0;
  logic [7:0]  tx_byte, ts_now;
  logic        tx_valid, tx_sof;
  logic [15:0] ovf;

  always #5 clk = ~clk;

  timestamp_tagger #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_PERIOD(SYNC_PERIOD)) dut (
    .clk_128M(clk), .reset_128M(rst), .tick_in(tick), .event_valid(ev), .event_data(evd),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(rdy), .tx_sof(tx_sof),
    .timestamp_now(ts_now), .overflow_count(ovf)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: events waiting in the FIFO, bytes still owed to the serializer.
  typedef struct { logic [7:0] ts; logic [DATA_W-1:0] data; int cyc; } ev_t;
  ev_t        m_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_ts, m_ts_prev, m_sync, m_sync_prev, p_byte;
  logic [15:0] m_ovf;
  bit  p_valid, p_ready, p_sof;
  int  cyc = 0, frame_pos = 0, hdr_cyc = 0, n_sync = 0;

  task automatic model_reset();
    m_q.delete(); exp_q.delete();
    m_ts = 0; m_ts_prev = 0; m_sync = 0; m_sync_prev = 0; m_ovf = 0;
    p_valid = 0; p_ready = 0; p_sof = 0; p_byte = 0; frame_pos = 0;
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    bit  elig, due;
    if (!rst) begin
      elig = (m_q.size() > 0) && (m_q[0].cyc < cyc - 1);
      due  = (m_sync_prev == 8'(SYNC_PERIOD));
      check_eq("ts_now", 32'(ts_now), 32'(m_ts));
      check_eq("overflow", 32'(ovf), 32'(m_ovf));
      if (p_valid && !p_ready) begin
        check_eq("hold_valid", 32'(tx_valid), 32'd1);
        check_eq("hold_byte", 32'(tx_byte), 32'(p_byte));
        check_eq("hold_sof", 32'(tx_sof), 32'(p_sof));
      end
      if (!p_valid && !tx_valid) check_eq("missed_launch", 32'(elig || due), 32'd0);
      if (tx_valid && !p_valid) begin
        hdr_cyc = cyc;
        frame_pos = 0;
        if (elig) begin
          e = m_q.pop_front();
          exp_q.push_back(8'hA5);
          exp_q.push_back(e.ts);
          for (int b = NB - 1; b >= 0; b--) exp_q.push_back(e.data[b*8 +: 8]);
          $display("cycle %0d: event frame ts=%02h data=%04h", cyc, e.ts, e.data);
        end else begin
          check_eq("sync_due", 32'(due), 32'd1);
          exp_q.push_back(8'h5A);
          exp_q.push_back(m_ts_prev);
          n_sync++;
          $display("cycle %0d: sync frame ts=%02h", cyc, m_ts_prev);
        end
        m_sync = 0;
      end
      if (tx_valid) check_eq("sof", 32'(tx_sof), 32'(frame_pos == 0));
      if (tx_valid && rdy) begin
        check_eq("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_eq("byte", 32'(tx_byte), 32'(exp_q.pop_front()));
        frame_pos++;
      end
      if (ev) begin
        if (m_q.size() >= FIFO_DEPTH) begin
          if (m_ovf != 16'hFFFF) m_ovf++;
        end else begin
          m_q.push_back('{ts: m_ts, data: evd, cyc: cyc});
        end
      end
      m_sync_prev = m_sync;
      m_ts_prev   = m_ts;
      if (tick) begin
        m_ts++;
        if (m_sync != 8'(SYNC_PERIOD)) m_sync++;
      end
      p_valid = tx_valid; p_ready = rdy; p_byte = tx_byte; p_sof = tx_sof;
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(tx_valid), 32'd0);
    check_eq({tag, "_sof"}, 32'(tx_sof), 32'd0);
    check_eq({tag, "_byte"}, 32'(tx_byte), 32'd0);
    check_eq({tag, "_ts"}, 32'(ts_now), 32'd0);
    check_eq({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 800; i++) begin
      next_cycle();
      tick = 1'b1; ev = 1'b0; rdy = 1'b1;
      if (m_q.size() == 0 && exp_q.size() == 0 && !tx_valid) break;
    end
    check_eq(tag, 32'(m_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    int  ev_cyc;
    bit  sent;
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1; rst = 1'b0;

    // 1: single event at ts 12, tick every fifth cycle
    sent = 0; ev_cyc = 0;
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      tick = (i % 5 == 4); ev = 1'b0; rdy = 1'b1;
      if (!sent && m_ts == 8'h12) begin
        ev = 1'b1; evd = 16'hBEEF; sent = 1; ev_cyc = cyc;
      end
    end
    check_eq("t1_latency", 32'(hdr_cyc - ev_cyc), 32'd2);

    // 2: idle stream, tick every cycle -> periodic sync frames across ts wrap
    n_sync = 0;
    for (int i = 0; i < 800; i++) begin
      next_cycle();
      tick = 1'b1; ev = 1'b0; rdy = 1'b1;
    end
    check_eq("t2_sync_frames", 32'(n_sync >= 5), 32'd1);
    drain("t2_drain");

    // 3: serializer stalled on a sync frame, ten events into an 8-deep FIFO
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      tick = 1'b1; ev = 1'b0; rdy = 1'b0;
      if (tx_valid) break;
    end
    check_eq("t3_stalled", 32'(tx_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      tick = 1'($urandom_range(0, 1)); ev = 1'b1; evd = 16'($urandom); rdy = 1'b0;
    end
    next_cycle();
    ev = 1'b0;
    next_cycle();
    check_eq("t3_overflow", 32'(ovf), 32'd2);
    drain("t3_drain");

    // 4: random ready, ticks and events
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rdy  = 1'($urandom_range(0, 1));
      tick = ($urandom_range(0, 2) != 0);
      ev   = ($urandom_range(0, 3) == 0);
      evd  = 16'($urandom);
    end
    drain("t4_drain");

    // 5: event and tick together at ts FF
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      tick = 1'b1; ev = 1'b0; rdy = 1'b1;
      if (m_ts == 8'hFF) begin
        ev = 1'b1; evd = 16'($urandom);
        break;
      end
    end
    next_cycle();
    ev = 1'b0;
    check_eq("t5_ts_wrap", 32'(ts_now), 32'd0);
    drain("t5_drain");

    // 6: asynchronous reset while a data byte is being held
    next_cycle();
    rst = 1'b1; tick = 1'b0; ev = 1'b0;
    model_reset();
    release_reset();
    next_cycle();
    ev = 1'b1; evd = 16'h1234; tick = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      ev = 1'b0;
      if (frame_pos == 2) break;
    end
    rdy = 1'b0;
    check_eq("t6_in_frame", 32'(tx_valid), 32'd1);
    #3;
    rst = 1'b1; tick = 1'b0; ev = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("t6_reset");
    release_reset();
    rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      tick = 1'b1; rdy = 1'($urandom_range(0, 1));
      ev = (i == 5); evd = 16'hC0DE;
    end
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
